// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main sequencing FSM of the multicycle RV32I core. Each instruction is walked
// through fetch, decode, execute, memory and writeback. The FSM drives every
// datapath mux/enable, the 2-bit ALU operation class, the memory request
// handshake, and a 32-bit retired-instruction counter.
//
// Ports
//   clk_i           rising-edge clock
//   reset_i         synchronous active-high reset (forces every output to 0)
//   op_i            opcode from the instruction register
//   fun3_i          funct3 from the instruction register
//   fun7_5_i        instruction bit 30
//   zero_i          ALU zero flag
//   mem_ready_i     memory completes the current request this cycle
//   mem_req_o       memory access request
//   mem_write_o     request is a store
//   adr_src_o       memory address select (0 = PC, 1 = ALUOut)
//   ir_write_o      latch fetched instruction and OldPC
//   pc_write_o      PC enable
//   reg_write_o     register file write enable
//   alu_src_a_o     ALU A select (00 PC, 01 OldPC, 10 rs1)
//   alu_src_b_o     ALU B select (00 rs2, 01 imm, 10 constant 4)
//   result_src_o    result select (00 ALUOut, 01 load data, 10 ALU result)
//   imm_src_o       immediate format (00 I, 01 S, 10 B, 11 J)
//   alu_op_o        ALU operation class (00 ADD, 01 SUB, 10 funct decode)
//   alu_fun7_5_o    bit 30 as forwarded to ALU control
//   illegal_instr_o one-cycle pulse on an unsupported opcode
//   instret_o       count of retired instructions
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  fun3_i,
    input  logic        fun7_5_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_write_o,
    output logic        adr_src_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        reg_write_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  imm_src_o,
    output logic [1:0]  alu_op_o,
    output logic        alu_fun7_5_o,
    output logic        illegal_instr_o,
    output logic [31:0] instret_o
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic        mem_req_s, mem_write_s, adr_src_s, ir_write_s;
    logic        pc_update_s, branch_s, reg_write_s, illegal_s, retire_s;
    logic        taken_s, fun7_5_s;
    logic [1:0]  src_a_s, src_b_s, result_src_s, imm_src_s, alu_op_s;

    // Next-state and per-state control outputs
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        mem_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;
        src_a_s      = 2'b00;
        src_b_s      = 2'b00;
        result_src_s = 2'b00;
        alu_op_s     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                src_b_s      = 2'b10;
                result_src_s = 2'b10;
                if (mem_ready_i) begin
                    ir_write_s  = 1'b1;
                    pc_update_s = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm, the branch/JAL target
                src_a_s = 2'b01;
                src_b_s = 2'b01;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                src_a_s = 2'b10;
                src_b_s = 2'b01;
                if (op_i == OP_LOAD) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
                if (mem_ready_i) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                src_a_s  = 2'b10;
                alu_op_s = 2'b10;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_s  = 2'b10;
                src_b_s  = 2'b01;
                alu_op_s = 2'b10;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_s  = 2'b10;
                alu_op_s = 2'b01;
                branch_s = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU makes OldPC+4
                src_a_s     = 2'b01;
                src_b_s     = 2'b10;
                pc_update_s = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Branch condition, immediate format and forwarded bit 30
    always_comb begin
        case (fun3_i)
            3'b000:  taken_s = zero_i;
            3'b001:  taken_s = ~zero_i;
            default: taken_s = 1'b0;
        endcase
        case (op_i)
            OP_STORE:  imm_src_s = 2'b01;
            OP_BRANCH: imm_src_s = 2'b10;
            OP_JAL:    imm_src_s = 2'b11;
            default:   imm_src_s = 2'b00;
        endcase
        // Only shifts keep bit 30 in I-type; ADDI with a negative imm must stay ADD
        if (state_q == S_EXECR) begin
            fun7_5_s = fun7_5_i;
        end else if (state_q == S_EXECI && fun3_i == 3'b101) begin
            fun7_5_s = fun7_5_i;
        end else begin
            fun7_5_s = 1'b0;
        end
        instret_d = retire_s ? (instret_q + 32'd1) : instret_q;
    end

    // Output stage: everything is held at 0 during a reset cycle
    always_comb begin
        if (reset_i) begin
            mem_req_o       = 1'b0;
            mem_write_o     = 1'b0;
            adr_src_o       = 1'b0;
            ir_write_o      = 1'b0;
            pc_write_o      = 1'b0;
            reg_write_o     = 1'b0;
            alu_src_a_o     = 2'b00;
            alu_src_b_o     = 2'b00;
            result_src_o    = 2'b00;
            imm_src_o       = 2'b00;
            alu_op_o        = 2'b00;
            alu_fun7_5_o    = 1'b0;
            illegal_instr_o = 1'b0;
            instret_o       = 32'd0;
        end else begin
            mem_req_o       = mem_req_s;
            mem_write_o     = mem_write_s;
            adr_src_o       = adr_src_s;
            ir_write_o      = ir_write_s;
            pc_write_o      = pc_update_s | (branch_s & taken_s);
            reg_write_o     = reg_write_s;
            alu_src_a_o     = src_a_s;
            alu_src_b_o     = src_b_s;
            result_src_o    = result_src_s;
            imm_src_o       = imm_src_s;
            alu_op_o        = alu_op_s;
            alu_fun7_5_o    = fun7_5_s;
            illegal_instr_o = illegal_s;
            instret_o       = instret_q;
        end
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset, fun7_5, zero, mem_ready;
    logic [6:0]  op;
    logic [2:0]  fun3;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, alu_op;
    logic        alu_fun7_5, illegal_instr;
    logic [31:0] instret;

    multicycle_control dut (
        .clk_i(clk), .reset_i(reset), .op_i(op), .fun3_i(fun3), .fun7_5_i(fun7_5),
        .zero_i(zero), .mem_ready_i(mem_ready), .mem_req_o(mem_req),
        .mem_write_o(mem_write), .adr_src_o(adr_src), .ir_write_o(ir_write),
        .pc_write_o(pc_write), .reg_write_o(reg_write), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .result_src_o(result_src), .imm_src_o(imm_src),
        .alu_op_o(alu_op), .alu_fun7_5_o(alu_fun7_5), .illegal_instr_o(illegal_instr),
        .instret_o(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
        int         fw;     // fetch wait cycles
        int         mw;     // data memory wait cycles
        int         cyc;
        int         irw;
        int         pcw;
        int         regw;
        int         memw;
        int         ill;
        int         ret;
        int         f75;
        int         aop10;
        int         ldwb;
    } vec_t;

    vec_t        tbl [0:15];
    vec_t        exp_q [$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_instret = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {14'd0, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, imm_src, alu_op, alu_fun7_5,
                illegal_instr, instret};
    endfunction

    // Runs one instruction starting in the first FETCH cycle (just after a negedge)
    // and returns once the DUT is back at the first cycle of the next FETCH.
    task automatic run_instr(input vec_t v);
        int   cyc = 0, fcnt = 0, mcnt = 0;
        int   irw = 0, pcw = 0, regw = 0, memw = 0, ill = 0, f75 = 0, aop10 = 0, ldwb = 0;
        logic prev_fetch = 1'b1, is_fetch, done = 1'b0;
        vec_t e;
        op = v.op; fun3 = v.f3; fun7_5 = v.f7; zero = v.zero;
        exp_q.push_back(v);
        model_instret = model_instret + 32'(v.ret);
        while (!done && cyc < 40) begin
            is_fetch = mem_req && !adr_src;
            if (cyc > 0 && is_fetch && !prev_fetch) begin
                done = 1'b1;
            end else begin
                if (mem_req && !adr_src) begin
                    mem_ready = (fcnt == v.fw); fcnt++;
                end else if (mem_req && adr_src) begin
                    mem_ready = (mcnt == v.mw); mcnt++;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                #1;
                irw   += int'(ir_write);
                pcw   += int'(pc_write);
                regw  += int'(reg_write);
                memw  += int'(mem_write);
                ill   += int'(illegal_instr);
                f75   += int'(alu_fun7_5);
                aop10 += int'(alu_op == 2'b10);
                ldwb  += int'(reg_write && result_src == 2'b01);
                prev_fetch = is_fetch;
                cyc++;
                @(negedge clk);
            end
        end
        e = exp_q.pop_front();
        if (!done) begin
            chk({e.name, " timeout"}, 64'd0, 64'd1);
        end
        chk({e.name, " cycles"},    64'(cyc),   64'(e.cyc));
        chk({e.name, " ir_write"},  64'(irw),   64'(e.irw));
        chk({e.name, " pc_write"},  64'(pcw),   64'(e.pcw));
        chk({e.name, " reg_write"}, 64'(regw),  64'(e.regw));
        chk({e.name, " mem_write"}, 64'(memw),  64'(e.memw));
        chk({e.name, " illegal"},   64'(ill),   64'(e.ill));
        chk({e.name, " fun7_5"},    64'(f75),   64'(e.f75));
        chk({e.name, " alu_op10"},  64'(aop10), 64'(e.aop10));
        chk({e.name, " load_wb"},   64'(ldwb),  64'(e.ldwb));
        chk({e.name, " instret"},   64'(instret), 64'(model_instret));
    endtask

    initial begin
        //                name        op           f3      f7    z     fw mw cyc irw pcw regw memw ill ret f75 a10 ldwb
        tbl[0]  = '{"add",      7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4,  1, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[1]  = '{"addi",     7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4,  1, 1, 1, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{"srai",     7'b0010011, 3'b101, 1'b1, 1'b0, 0, 0, 4,  1, 1, 1, 0, 0, 1, 1, 1, 0};
        tbl[3]  = '{"or_fw1",   7'b0110011, 3'b110, 1'b0, 1'b1, 1, 0, 5,  1, 1, 1, 0, 0, 1, 0, 1, 0};
        tbl[4]  = '{"lw_wait",  7'b0000011, 3'b010, 1'b0, 1'b0, 2, 3, 10, 1, 1, 1, 0, 0, 1, 0, 0, 1};
        tbl[5]  = '{"lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5,  1, 1, 1, 0, 0, 1, 0, 0, 1};
        tbl[6]  = '{"sw",       7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 4,  1, 1, 0, 1, 0, 1, 0, 0, 0};
        tbl[7]  = '{"sw_wait",  7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2, 6,  1, 1, 0, 3, 0, 1, 0, 0, 0};
        tbl[8]  = '{"beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3,  1, 2, 0, 0, 0, 1, 0, 0, 0};
        tbl[9]  = '{"beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 3,  1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[10] = '{"bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3,  1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[11] = '{"bne_z0",   7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3,  1, 2, 0, 0, 0, 1, 0, 0, 0};
        tbl[12] = '{"blt_z1",   7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 3,  1, 1, 0, 0, 0, 1, 0, 0, 0};
        tbl[13] = '{"jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4,  1, 2, 1, 0, 0, 1, 0, 0, 0};
        tbl[14] = '{"illegal0", 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 3,  1, 1, 0, 0, 1, 0, 0, 0, 0};
        tbl[15] = '{"illegal7f",7'b1111111, 3'b000, 1'b0, 1'b0, 1, 0, 4,  1, 1, 0, 0, 1, 0, 0, 0, 0};

        reset = 1'b1; op = 7'd0; fun3 = 3'd0; fun7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1 chk("reset_outs_zero", all_outs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_reset_fetch", {62'd0, mem_req, adr_src}, 64'd2);

        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i]);
        end

        // Reset while a load waits in MEMREAD abandons it without retiring
        op = 7'b0000011; fun3 = 3'b010; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1 chk("memread_entry", {62'd0, mem_req, adr_src}, 64'd3);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("reset_mid_memread", all_outs(), 64'd0);
            @(negedge clk);
        end
        reset = 1'b0;
        model_instret = 32'd0;
        #1;
        chk("after_reset_fetch", {62'd0, mem_req, adr_src}, 64'd2);
        chk("after_reset_instret", 64'(instret), 64'd0);
        chk("after_reset_no_enables", {62'd0, reg_write, mem_write}, 64'd0);

        // Counter wrap: preload the counter to all ones while FETCH waits
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        #1 chk("preload_instret", 64'(instret), 64'hFFFF_FFFF);
        model_instret = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("preload_hold", 64'(instret), 64'hFFFF_FFFF);
        run_instr(tbl[9]);
        chk("wrap_to_zero", 64'(instret), 64'd0);
        run_instr(tbl[14]);
        run_instr(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
